// File: rtl/jam_perm_sched.sv
// jam_perm_sched: walks every worker->job permutation in lexicographic order,
// hands each one to the cost block (start/done handshake) and, after the
// strictly descending final permutation, captures the cost block's minimum
// cost and match count and pulses Valid. One run per reset.
// Optional feature macro: PERM_COUNT_EN adds the 16-bit perm_count port that
// counts start pulses issued in the current run (saturating).
module jam_perm_sched #(
  parameter int NUM     = 8,
  parameter int COST_W  = 10,
  parameter int MATCH_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               go,
  input  logic               cal_done,
  input  logic [COST_W-1:0]  cal_min,
  input  logic [MATCH_W-1:0] cal_match,
  output logic               cal_start,
  output logic [3*NUM-1:0]   arrange_flat,
  output logic               busy,
  output logic               Valid,
  output logic [COST_W-1:0]  MinCost,
  output logic [MATCH_W-1:0] MatchCount
`ifdef PERM_COUNT_EN
  ,
  output logic [15:0]        perm_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ACK, S_BUSYW, S_PIVOT, S_PERM, S_CAPT, S_FIN
  } state_t;

  state_t state, state_next;

  // Index width is fixed at 3 bits, so the lane array always has 8 entries;
  // only lanes 0..NUM-1 take part in the permutation and reach the port.
  logic [2:0] arr      [8];
  logic [2:0] arr_next [8];
  logic [2:0] swapped  [8];
  logic [2:0] pivot;
  logic [2:0] piv_idx;
  logic       piv_found;
  logic [2:0] succ_idx;

  // Pivot search: largest k with a[k] < a[k+1]; none means last permutation.
  always_comb begin
    piv_found = 1'b0;
    piv_idx   = 3'd0;
    for (int k = 0; k < NUM - 1; k++) begin
      if (arr[k] < arr[k+1]) begin
        piv_found = 1'b1;
        piv_idx   = 3'(k);
      end
    end
  end

  // Successor step: swap a[p] with the rightmost larger element, then reverse the tail.
  always_comb begin
    succ_idx = pivot;
    for (int k = 0; k < NUM; k++) begin
      if ((k > int'(pivot)) && (arr[k] > arr[pivot])) begin
        succ_idx = 3'(k);
      end
    end
    for (int i = 0; i < 8; i++) begin
      swapped[i] = arr[i];
    end
    swapped[pivot]    = arr[succ_idx];
    swapped[succ_idx] = arr[pivot];
    for (int i = 0; i < 8; i++) begin
      arr_next[i] = swapped[i];
      if ((i < NUM) && (i > int'(pivot))) begin
        arr_next[i] = swapped[3'(NUM + int'(pivot) - i)];
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    cal_start  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        cal_start  = 1'b1;
        busy       = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: begin
        busy = 1'b1;
        if (!cal_done) state_next = S_BUSYW;
      end
      S_BUSYW: begin
        busy = 1'b1;
        if (cal_done) state_next = S_PIVOT;
      end
      S_PIVOT: begin
        busy       = 1'b1;
        state_next = piv_found ? S_PERM : S_CAPT;
      end
      S_PERM: begin
        busy       = 1'b1;
        state_next = S_ISSUE;
      end
      S_CAPT: begin
        busy       = 1'b1;
        state_next = S_FIN;
      end
      S_FIN: begin
        state_next = S_FIN;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Permutation lanes, pivot register, result capture and the Valid pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 8; k++) begin
        arr[k] <= 3'(k);
      end
      pivot      <= 3'd0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
    end else begin
      Valid <= (state == S_CAPT);
      if (state == S_PIVOT) begin
        pivot <= piv_idx;
      end
      if (state == S_PERM) begin
        for (int k = 0; k < 8; k++) begin
          arr[k] <= arr_next[k];
        end
      end
      if (state == S_CAPT) begin
        MinCost    <= cal_min;
        MatchCount <= cal_match;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      assign arrange_flat[3*gi +: 3] = arr[gi];
    end
  endgenerate

`ifdef PERM_COUNT_EN
  // Start-pulse counter: cleared when a run is accepted, saturates at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perm_count <= 16'd0;
    end else if ((state == S_IDLE) && go) begin
      perm_count <= 16'd0;
    end else if (cal_start && (perm_count != 16'hFFFF)) begin
      perm_count <= perm_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jam_perm_sched.sv
// Bench for jam_perm_sched: a NUM=8 instance checked against a table of known
// lexicographic permutations, and a NUM=4 instance run with random cost tables
// and random cost-block latencies against an enumeration-based reference.
module tb_jam_perm_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NUM=8 instance
  logic        rst8, go8, done8, start8, busy8, valid8;
  logic [23:0] arr8;
  logic [9:0]  min8_in, mc8;
  logic [3:0]  match8_in, mt8;
  // NUM=4 instance
  logic        rst4, go4, done4, start4, busy4, valid4;
  logic [11:0] arr4;
  logic [9:0]  min4_in, mc4;
  logic [7:0]  match4_in, mt4;
`ifdef PERM_COUNT_EN
  logic [15:0] pc8, pc4;
`endif

  jam_perm_sched #(.NUM(8), .COST_W(10), .MATCH_W(4)) dut8 (
    .CLK(clk), .RST(rst8), .go(go8), .cal_done(done8), .cal_min(min8_in),
    .cal_match(match8_in), .cal_start(start8), .arrange_flat(arr8), .busy(busy8),
    .Valid(valid8), .MinCost(mc8), .MatchCount(mt8)
`ifdef PERM_COUNT_EN
    , .perm_count(pc8)
`endif
  );

  jam_perm_sched #(.NUM(4), .COST_W(10), .MATCH_W(8)) dut4 (
    .CLK(clk), .RST(rst4), .go(go4), .cal_done(done4), .cal_min(min4_in),
    .cal_match(match4_in), .cal_start(start4), .arrange_flat(arr4), .busy(busy4),
    .Valid(valid4), .MinCost(mc4), .MatchCount(mt4)
`ifdef PERM_COUNT_EN
    , .perm_count(pc4)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the falling edge (after the cost-block models ran).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Worker k's job is hex digit k counted from the most significant nibble.
  function automatic logic [23:0] pack8(input logic [31:0] d);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[3*k +: 3] = d[28-4*k +: 3];
    return r;
  endfunction

  // Golden cost table for NUM=4 and the full permutation list in lex order.
  int          c4 [4][4];
  logic [11:0] exp4 [$];

  function automatic int cost_of(input logic [11:0] a);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += c4[k][a[3*k +: 3]];
    return s;
  endfunction

  // Cost block model for NUM=8: done low 2 cycles after start, high 10 later.
  int ph8 = 0, cnt8 = 0;
  always @(negedge clk) begin
    if (rst8) begin
      done8 = 1'b1; ph8 = 0; cnt8 = 0;
    end else if (start8) begin
      ph8 = 1; cnt8 = 2;
    end else if (ph8 == 1) begin
      cnt8--;
      if (cnt8 == 0) begin done8 = 1'b0; ph8 = 2; cnt8 = 10; end
    end else if (ph8 == 2) begin
      cnt8--;
      if (cnt8 == 0) begin done8 = 1'b1; ph8 = 0; end
    end
  end

  // Cost block model for NUM=4: random latencies, running min and tie count.
  int ph4 = 0, cnt4 = 0, n4 = 0, run_min = 0, run_cnt = 0;
  logic [11:0] cap4;
  always @(negedge clk) begin
    int c;
    if (rst4) begin
      done4 = 1'b1; ph4 = 0; cnt4 = 0; n4 = 0;
      run_min = 1023; run_cnt = 0; min4_in = 10'h3FF; match4_in = 8'd0;
    end else if (start4) begin
      if (n4 < 24) chk("arr4_at_start", 32'(arr4), 32'(exp4[n4]));
      else chk("arr4_extra_start", 32'(n4 + 1), 32'd24);
      n4++;
      cap4 = arr4; ph4 = 1; cnt4 = $urandom_range(1, 3);
    end else if (ph4 == 1) begin
      cnt4--;
      if (cnt4 == 0) begin done4 = 1'b0; ph4 = 2; cnt4 = $urandom_range(1, 6); end
    end else if (ph4 == 2) begin
      cnt4--;
      if (cnt4 == 0) begin
        c = cost_of(cap4);
        if (c < run_min) begin run_min = c; run_cnt = 1; end
        else if (c == run_min) run_cnt++;
        min4_in = 10'(run_min); match4_in = 8'(run_cnt); done4 = 1'b1; ph4 = 0;
      end
    end
  end

  typedef struct {
    int          n;       // start pulse number within the run
    logic [31:0] digits;  // expected arrangement, worker 0 first
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ti, n8, ref_min, ref_cnt, got;
    logic [11:0] a;
    int d [4];
    bit ok;

    tbl[0] = '{1,   32'h01234567};
    tbl[1] = '{2,   32'h01234576};
    tbl[2] = '{3,   32'h01234657};
    tbl[3] = '{6,   32'h01234765};
    tbl[4] = '{7,   32'h01235467};
    tbl[5] = '{24,  32'h01237654};
    tbl[6] = '{25,  32'h01243567};
    tbl[7] = '{121, 32'h01324567};

    // Reference permutation list: all 4-digit base-4 tuples with distinct digits,
    // in increasing numeric order (worker 0 most significant) = lexicographic.
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 4; k++) d[k] = (v >> (2 * (3 - k))) & 3;
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (d[i] == d[j]) ok = 1'b0;
      if (ok) begin
        a = '0;
        for (int k = 0; k < 4; k++) a[3*k +: 3] = 3'(d[k]);
        exp4.push_back(a);
      end
    end

    rst8 = 1'b1; rst4 = 1'b1; go8 = 1'b0; go4 = 1'b0;
    min8_in = '0; match8_in = '0;
    for (int i = 0; i < 3; i++) step();

    // Reset state
    chk("rst8_arrange", 32'(arr8), 32'h00FAC688);
    chk("rst8_busy", 32'(busy8), 32'd0);
    chk("rst8_valid", 32'(valid8), 32'd0);
    chk("rst8_start", 32'(start8), 32'd0);
    chk("rst4_arrange", 32'(arr4), 32'h688);
    chk("rst4_mincost", 32'(mc4), 32'd0);

    // NUM=8: table of known permutations; a go while busy must not restart.
    rst8 = 1'b0;
    step();
    go8 = 1'b1; step(); go8 = 1'b0;
    chk("busy8_after_go", 32'(busy8), 32'd1);
    ti = 0; n8 = 0;
    for (int cyc = 0; cyc < 4000 && ti < 8; cyc++) begin
      go8 = (cyc == 100);
      if (start8) begin
        n8++;
        if (n8 == tbl[ti].n) begin
          chk($sformatf("arr8_start%0d", tbl[ti].n), 32'(arr8), 32'(pack8(tbl[ti].digits)));
          ti++;
        end
      end
      step();
    end
    go8 = 1'b0;
    chk("arr8_table_reached", 32'(ti), 32'd8);

    // Reset in BUSYW: outputs return to reset values immediately.
    got = 0;
    for (int cyc = 0; cyc < 100 && got == 0; cyc++) begin
      if (busy8 && !done8 && !start8) got = 1; else step();
    end
    chk("busyw8_reached", 32'(got), 32'd1);
    rst8 = 1'b1;
    #1;
    chk("midrst8_arrange", 32'(arr8), 32'h00FAC688);
    chk("midrst8_busy", 32'(busy8), 32'd0);
    chk("midrst8_valid", 32'(valid8), 32'd0);
    chk("midrst8_start", 32'(start8), 32'd0);
    step(); step();
    rst8 = 1'b0; step();
    go8 = 1'b1; step(); go8 = 1'b0;
    n8 = 0;
    for (int cyc = 0; cyc < 100 && n8 < 2; cyc++) begin
      if (start8) begin
        n8++;
        chk($sformatf("restart8_start%0d", n8), 32'(arr8),
            32'(pack8((n8 == 1) ? 32'h01234567 : 32'h01234576)));
      end
      step();
    end
    chk("restart8_starts", 32'(n8), 32'd2);
    rst8 = 1'b1;

    // NUM=4: random cost tables, full runs.
    for (int trial = 0; trial < 3; trial++) begin
      rst4 = 1'b1;
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < 4; j++) c4[w][j] = $urandom_range(0, 31);
      ref_min = 1 << 30; ref_cnt = 0;
      foreach (exp4[i]) begin
        if (cost_of(exp4[i]) < ref_min) begin ref_min = cost_of(exp4[i]); ref_cnt = 1; end
        else if (cost_of(exp4[i]) == ref_min) ref_cnt++;
      end
      step(); step();
      chk("trial_rst4_arrange", 32'(arr4), 32'h688);
      rst4 = 1'b0; step();
      go4 = 1'b1; step(); go4 = 1'b0;
      chk("busy4_after_go", 32'(busy4), 32'd1);
      got = 0;
      for (int cyc = 0; cyc < 3000 && got == 0; cyc++) begin
        go4 = (cyc == 30);
        if (valid4) got = 1; else step();
      end
      go4 = 1'b0;
      chk("valid4_seen", 32'(got), 32'd1);
      chk("fin4_starts", 32'(n4), 32'd24);
      chk("fin4_last_arrange", 32'(arr4), 32'h053);
      chk("fin4_busy", 32'(busy4), 32'd0);
      chk("fin4_mincost", 32'(mc4), 32'(ref_min));
      chk("fin4_matchcount", 32'(mt4), 32'(ref_cnt));
`ifdef PERM_COUNT_EN
      chk("fin4_perm_count", 32'(pc4), 32'd24);
`endif
      step();
      chk("valid4_one_cycle", 32'(valid4), 32'd0);
      // go in FIN is ignored
      go4 = 1'b1; step(); go4 = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("fin4_go_no_start", 32'(n4), 32'd24);
      chk("fin4_hold_mincost", 32'(mc4), 32'(ref_min));
      chk("fin4_hold_valid", 32'(valid4), 32'd0);
    end

    // NUM=4: reset mid-run clears held results too.
    rst4 = 1'b1; step(); step();
    rst4 = 1'b0; step();
    go4 = 1'b1; step(); go4 = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 1000 && got == 0; cyc++) begin
      if (n4 >= 5 && busy4 && !done4 && !start4) got = 1; else step();
    end
    chk("busyw4_reached", 32'(got), 32'd1);
    rst4 = 1'b1;
    #1;
    chk("midrst4_arrange", 32'(arr4), 32'h688);
    chk("midrst4_busy", 32'(busy4), 32'd0);
    chk("midrst4_valid", 32'(valid4), 32'd0);
    chk("midrst4_mincost", 32'(mc4), 32'd0);
    chk("midrst4_matchcount", 32'(mt4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
